// File: rtl/deserializer.sv
// Rebuilds MSB-first serial frames into left-aligned parallel words with a bit-count
// modifier; frames shorter than MIN_FRAME_LEN are discarded with a drop pulse.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int MIN_FRAME_LEN  = 3
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] data_o,
    output logic [DATA_MOD_WIDTH-1:0] data_mod_o,
    output logic                      data_val_o,
    output logic                      busy_o,
    output logic                      drop_o
);

    localparam int CNT_W = DATA_MOD_WIDTH + 1;
    localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(DATA_BUS_WIDTH);
    localparam logic [CNT_W-1:0]          CNT_MIN  = CNT_W'(MIN_FRAME_LEN);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_MOD_WIDTH-1:0] TOP_IDX  = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        RECV_S = 1'b1
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [CNT_W-1:0]            bit_cnt_r;
    logic [CNT_W-1:0]            bit_cnt_nxt_s;
    logic [DATA_BUS_WIDTH-1:0]   shift_r;
    logic [DATA_BUS_WIDTH-1:0]   shift_nxt_s;
    logic [DATA_BUS_WIDTH-1:0]   shift_upd_s;
    logic [DATA_MOD_WIDTH-1:0]   idx_s;
    logic                        emit_s;
    logic                        drop_s;
    logic [DATA_BUS_WIDTH-1:0]   emit_data_s;
    logic [DATA_MOD_WIDTH-1:0]   emit_mod_s;
    logic [DATA_BUS_WIDTH-1:0]   data_r;
    logic [DATA_MOD_WIDTH-1:0]   mod_r;
    logic                        val_r;
    logic                        drop_r;

    // Shift register with the incoming bit placed at W-1-bit_cnt (bit_cnt is 0 in idle).
    always_comb begin
        idx_s              = TOP_IDX - bit_cnt_r[DATA_MOD_WIDTH-1:0];
        shift_upd_s        = shift_r;
        shift_upd_s[idx_s] = ser_data_i;
    end

    // Next-state, counter, shift register and emit/drop decisions.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        emit_s        = 1'b0;
        drop_s        = 1'b0;
        emit_data_s   = shift_upd_s;
        emit_mod_s    = '0;
        case (state_r)
            IDLE_S: begin
                if (ser_data_val_i) begin
                    shift_nxt_s   = shift_upd_s;
                    bit_cnt_nxt_s = CNT_ONE;
                    state_nxt_s   = RECV_S;
                end else begin
                    state_nxt_s   = IDLE_S;
                end
            end
            RECV_S: begin
                if (ser_data_val_i) begin
                    if ((bit_cnt_r + CNT_ONE) == CNT_FULL) begin
                        // Full word: k mod W is 0, the next valid bit opens a new frame.
                        emit_s        = 1'b1;
                        emit_data_s   = shift_upd_s;
                        emit_mod_s    = '0;
                        shift_nxt_s   = '0;
                        bit_cnt_nxt_s = '0;
                        state_nxt_s   = IDLE_S;
                    end else begin
                        shift_nxt_s   = shift_upd_s;
                        bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                    end
                end else begin
                    if (bit_cnt_r >= CNT_MIN) begin
                        emit_s      = 1'b1;
                        emit_data_s = shift_r;
                        emit_mod_s  = bit_cnt_r[DATA_MOD_WIDTH-1:0];
                    end else begin
                        drop_s      = 1'b1;
                    end
                    shift_nxt_s   = '0;
                    bit_cnt_nxt_s = '0;
                    state_nxt_s   = IDLE_S;
                end
            end
            default: begin
                shift_nxt_s   = '0;
                bit_cnt_nxt_s = '0;
                state_nxt_s   = IDLE_S;
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r   <= IDLE_S;
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Output registers: word and modifier hold between emits, strobes pulse.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_r <= '0;
            mod_r  <= '0;
            val_r  <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            if (emit_s) begin
                data_r <= emit_data_s;
                mod_r  <= emit_mod_s;
            end else begin
                data_r <= data_r;
                mod_r  <= mod_r;
            end
            val_r  <= emit_s;
            drop_r <= drop_s;
        end
    end

    assign data_o     = data_r;
    assign data_mod_o = mod_r;
    assign data_val_o = val_r;
    assign drop_o     = drop_r;
    assign busy_o     = (state_r == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed vector table, reset/back-to-back/split
// sequences, and random serial traffic checked against a frame-level reference model.
module tb_deserializer;

    localparam int W    = 16;
    localparam int MW   = 4;
    localparam int MINL = 3;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          ser_data = 1'b0;
    logic          ser_val = 1'b0;
    logic [W-1:0]  data_o;
    logic [MW-1:0] data_mod_o;
    logic          data_val_o;
    logic          busy_o;
    logic          drop_o;

    deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW), .MIN_FRAME_LEN(MINL)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .ser_data_i(ser_data), .ser_data_val_i(ser_val),
        .data_o(data_o), .data_mod_o(data_mod_o), .data_val_o(data_val_o),
        .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            drop;
        logic [W-1:0]  data;
        logic [MW-1:0] mod_v;
        int            cyc;
    } ev_t;

    typedef struct {
        logic [63:0]   bits;
        int            len;
        logic [W-1:0]  exp_data;
        logic [MW-1:0] exp_mod;
        int            exp_val;
        int            exp_drop;
    } vec_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_val = 0;
    int            n_drop = 0;
    int            m_cnt = 0;
    logic [W-1:0]  m_word = '0;
    logic [W-1:0]  last_data = '0;
    logic [MW-1:0] last_mod = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor: every strobe must match the oldest expected event and its edge.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            check("busy", 32'(busy_o), 32'(m_cnt != 0));
            if (data_val_o || drop_o) begin
                check("val_drop_exclusive", 32'(data_val_o & drop_o), 32'd0);
                if (data_val_o) n_val++;
                if (drop_o) n_drop++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_drop", 32'(drop_o), 32'(e.drop));
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("data", 32'(data_o), 32'(e.data));
                    check("data_mod", 32'(data_mod_o), 32'(e.mod_v));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missing_pulse", 32'd0, 32'd1);
            end
        end
    end

    task automatic push_emit(logic [W-1:0] d, logic [MW-1:0] m, int c);
        exp_q.push_back('{1'b0, d, m, c});
        last_data = d;
        last_mod  = m;
    endtask

    // Reference: bits accumulate MSB-first; every W bits form a word, a gap closes the rest.
    task automatic drive_bit(bit b);
        @(negedge clk);
        ser_val  = 1'b1;
        ser_data = b;
        m_cnt++;
        m_word[W-m_cnt] = b;
        if (m_cnt == W) begin
            push_emit(m_word, '0, cyc + 1);
            m_cnt  = 0;
            m_word = '0;
        end
    endtask

    task automatic drive_gap(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser_val  = 1'b0;
            ser_data = 1'($urandom);
            if (i == 0 && m_cnt > 0) begin
                if (m_cnt >= MINL) push_emit(m_word, MW'(m_cnt % W), cyc + 1);
                else exp_q.push_back('{1'b1, last_data, last_mod, cyc + 1});
                m_cnt  = 0;
                m_word = '0;
            end
        end
    endtask

    task automatic send(logic [63:0] bits, int len, int gap);
        for (int i = 0; i < len; i++) drive_bit(bits[len-1-i]);
        drive_gap(gap);
    endtask

    task automatic check_after(string name, int v0, int d0, logic [W-1:0] ed, logic [MW-1:0] em,
                               int ev, int edr);
        repeat (2) @(negedge clk);
        check({name, "_data"}, 32'(data_o), 32'(ed));
        check({name, "_mod"}, 32'(data_mod_o), 32'(em));
        check({name, "_nval"}, 32'(n_val - v0), 32'(ev));
        check({name, "_ndrop"}, 32'(n_drop - d0), 32'(edr));
    endtask

    initial begin
        vec_t vecs[6];
        int   v0, d0, len;

        vecs[0] = '{64'hA5C3, 16, 16'hA5C3, 4'd0, 1, 0};
        vecs[1] = '{64'h16, 5, 16'hB000, 4'd5, 1, 0};
        vecs[2] = '{64'h3, 2, 16'hB000, 4'd5, 0, 1};
        vecs[3] = '{64'h7, 3, 16'hE000, 4'd3, 1, 0};
        vecs[4] = '{64'h7FFF, 15, 16'hFFFE, 4'd15, 1, 0};
        vecs[5] = '{64'h0, 1, 16'hFFFE, 4'd15, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_mod", 32'(data_mod_o), 32'd0);
        check("rst_val", 32'(data_val_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_drop", 32'(drop_o), 32'd0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v0 = n_val;
            d0 = n_drop;
            send(vecs[i].bits, vecs[i].len, 1);
            check_after($sformatf("vec%0d", i), v0, d0, vecs[i].exp_data, vecs[i].exp_mod,
                        vecs[i].exp_val, vecs[i].exp_drop);
        end

        // Back-to-back full words, then a 20-bit frame split into 16 + 4.
        v0 = n_val; d0 = n_drop;
        send(64'hFFFF_0001, 32, 1);
        check_after("b2b", v0, d0, 16'h0001, 4'd0, 2, 0);
        v0 = n_val; d0 = n_drop;
        send(64'hABCDE, 20, 1);
        check_after("split", v0, d0, 16'hE000, 4'd4, 2, 0);

        // Reset in the middle of a 7-bit partial frame.
        for (int i = 0; i < 7; i++) drive_bit(1'b1);
        @(negedge clk);
        arst_n    = 1'b0;
        ser_val   = 1'b0;
        m_cnt     = 0;
        m_word    = '0;
        last_data = '0;
        last_mod  = '0;
        #1;
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_mod", 32'(data_mod_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_val", 32'(data_val_o | drop_o), 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        v0 = n_val; d0 = n_drop;
        send(64'h7, 3, 1);
        check_after("post_rst", v0, d0, 16'hE000, 4'd3, 1, 0);

        // Random serial traffic, mostly legal lengths with some short and over-long frames.
        for (int i = 0; i < 150; i++) begin
            if (i % 5 == 4) len = $urandom_range(1, 24);
            else len = $urandom_range(MINL, W);
            send({$urandom, $urandom}, len, $urandom_range(1, 3));
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
